// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types for the load/store unit
// Purpose: control-unit opcode constants, access-size encodings (funct3),
//          LSU state encoding and the alignment helper.
package load_store_unit_pkg;

    localparam logic [6:0] CU_LOAD   = 7'b0000011;
    localparam logic [6:0] CU_STORE  = 7'b0100011;
    localparam logic [6:0] CU_OP     = 7'b0110011;
    localparam logic [6:0] CU_OP_IMM = 7'b0010011;
    localparam logic [6:0] CU_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_DONE
    } lsu_state_t;

    // funct3[1:0] carries the size; any encoding that is not byte or
    // halfword (including unsupported ones) is handled as a word.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~addr[0];
            default: return (addr == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// rtl/load_store_unit_load_extend.sv - load lane select and sign/zero extension
// Purpose: picks the addressed byte/halfword out of the read word and extends it.
// Ports:   rdata     - read word from memory
//          addr      - byte offset within the word
//          funct3    - access size/sign
//          load_data - extended result
module load_store_unit_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr, 3'b000} +: 8];
    assign half_sel = rdata[{addr[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rdata;
        case (funct3)
            LSU_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_H:   load_data = {{16{half_sel[15]}}, half_sel};
            LSU_BU:  load_data = {24'h0, byte_sel};
            LSU_HU:  load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage with req/ack data bus
// Purpose: issues one load or store per instruction, stalls the core while it
//          is outstanding, returns extended load data, flags misalignment and
//          bus timeouts.
// Ports:   clk, nRst (async active-low)
//          alu_result, store_data, funct3, mem_read, mem_write - from execute
//          mem_rdata, mem_ack                                  - from memory
//          mem_addr, mem_wdata, mem_wstrb, mem_ren, mem_wen    - to memory
//          load_data, lsu_stall, misaligned, bus_error         - to core
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [31:0]       store_data,
    input  logic [2:0]        funct3,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [31:0]       load_data,
    output logic              lsu_stall,
    output logic              misaligned,
    output logic              bus_error
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       data_q, data_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              bus_error_q, bus_error_d;

    logic [31:0]       ext_data;
    logic              timeout_hit;

    load_store_unit_load_extend u_load_extend (
        .rdata     (mem_rdata),
        .addr      (addr_q[1:0]),
        .funct3    (funct3_q),
        .load_data (ext_data)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Bus fields come straight from the latched instruction so they stay
    // stable for the whole request and read as zero after reset.
    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        mem_wdata = data_q;
        mem_wstrb = 4'b0000;
        case (funct3_q[1:0])
            2'b00:   mem_wdata = {4{data_q[7:0]}};
            2'b01:   mem_wdata = {2{data_q[15:0]}};
            default: mem_wdata = data_q;
        endcase
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00:   mem_wstrb = 4'b0001 << addr_q[1:0];
                2'b01:   mem_wstrb = 4'b0011 << addr_q[1:0];
                default: mem_wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        data_d      = data_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        bus_error_d = 1'b0;
        lsu_stall   = 1'b0;
        misaligned  = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (mem_read || mem_write) begin
                    if (is_aligned(funct3, alu_result[1:0])) begin
                        lsu_stall = 1'b1;
                        addr_d    = alu_result;
                        funct3_d  = funct3;
                        data_d    = store_data;
                        // Both strobes high is illegal; the load wins.
                        we_d      = mem_write & ~mem_read;
                        cnt_d     = '0;
                        state_d   = LSU_REQ;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            LSU_REQ: begin
                lsu_stall = 1'b1;
                mem_ren   = ~we_q;
                mem_wen   = we_q;
                cnt_d     = cnt_q + CNT_W'(1);
                if (mem_ack) begin
                    if (!we_q) begin
                        load_data_d = ext_data;
                    end
                    state_d = LSU_DONE;
                end else if (timeout_hit) begin
                    load_data_d = 32'h0;
                    bus_error_d = 1'b1;
                    state_d     = LSU_DONE;
                end
            end
            // The finished instruction is still on the inputs here, so DONE
            // must not look at them or it would issue the access twice.
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= LSU_IDLE;
            addr_q      <= '0;
            funct3_q    <= 3'b000;
            data_q      <= 32'h0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            load_data_q <= 32'h0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            data_q      <= data_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign load_data = load_data_q;
    assign bus_error = bus_error_q;

endmodule
